screen_msg_builder: RTL and testbench
=====================================

// Module: screen_msg_builder
// PURPOSE
//  Upstream feeder of the screen UART transmitter. Watches the piano key bitmap
//  and, on every change, builds a short ASCII message: clear-screen, note name,
//  octave digit. It emits the message one byte at a time as 10-bit UART frames
//  {stop=1, data[7:0], start=0}, LSB sent first, over a valid/ready handshake.
//  One message is also sent after reset as a boot refresh.
// PARAMETERS
//  NUM_KEYS    8      keys monitored, 1..8; key i maps to note table entry i
//  CLEAR_BYTE  8'h0C  first byte of every message (display clear command)
// PORTS
//  clk          in   1         system clock
//  reset_n      in   1         asynchronous, active-low reset
//  keys         in   NUM_KEYS  raw key levels, async to clk, 1 = pressed
//  tx_ready     in   1         transmitter idle/ready (its oready)
//  frame_valid  out  1         one-cycle frame strobe (to transmitter ovalid)
//  frame_data   out  10        frame {1'b1, byte, 1'b0} (to inputScreen)
//  busy         out  1         high from message start until last byte acked
// BEHAVIOUR
//  Reset: frame_valid=0, frame_data=10'h3FF, busy=0, sync/snapshot regs=0,
//   byte_idx=0, pending=1 (boot refresh), state=IDLE.
//  keys pass through a 2-flop synchronizer. A change is sync output != snapshot.
//   On a change, set pending=1 and copy the sync output into snapshot.
//  Note select: the lowest pressed index wins. Table: C4 D4 E4 F4 G4 A4 B4 C5.
//   No key pressed -> "--".
//  Message bytes: [0] CLEAR_BYTE, [1] letter, [2] octave digit or '-'.
//   MSG_LEN = 3.
//  FSM:
//   IDLE:     pending -> LOAD.
//   LOAD:     latch the message from snapshot; pending=0; byte_idx=0; busy=1;
//             -> WAIT_RDY.
//   WAIT_RDY: tx_ready==1 -> SEND.
//   SEND:     frame_valid=1 for exactly 1 cycle, frame_data=frame(byte_idx);
//             -> WAIT_ACK.
//   WAIT_ACK: tx_ready==0 seen (transmitter accepted) -> advance.
//             Advance: byte_idx==MSG_LEN-1 -> busy=0, IDLE; else byte_idx++,
//             -> WAIT_RDY.
//  frame_valid is never asserted unless tx_ready was high the previous cycle.
//   This prevents a duplicate accept when the transmitter reenters idle with
//   oready still low.
//  frame_data holds its last value between strobes. It is 10'h3FF only after
//   reset.
//  Latency: a key edge produces frame_valid of byte 0 no sooner than 5 clk,
//   given tx_ready=1.
//  Key change mid-message: the current message completes unaltered. The new
//   snapshot is sent as the next message. Multiple changes coalesce, so only
//   the latest state is sent.
//  A change in the same cycle as LOAD is captured: pending re-sets, since set
//   has priority over clear.
//  tx_ready stuck low: wait indefinitely, with no timeout.
//  Reset mid-message: abort immediately. Restart with the boot refresh.
// CONFIGURATION
//  SCREEN_MSG_CRLF_EN defined: MSG_LEN=5, with bytes [3]=8'h0D, [4]=8'h0A
//   appended.
//  Undefined: MSG_LEN=3, no line terminator.
// STRUCTURE
//  Package screen_pkg holds:
//   FRAME_BITS=10, BYTE_CR, BYTE_LF, BYTE_DASH;
//   note ASCII table (letter, digit) x8;
//   state_t enum {IDLE, LOAD, WAIT_RDY, SEND, WAIT_ACK};
//   function make_frame(byte) -> {1'b1, byte, 1'b0}.
//  Sub-module key_change_detect: synchronizer, snapshot and change pulse.
//  Message table and FSM live in the top.
// TESTING
//  1 Reset release, keys=0, tx_ready=1 -> strobes 10'h218, 10'h25A, 10'h25A
//    ('--'); busy falls after 3rd ack.
//  2 keys=8'h01 -> 10'h218, 10'h286 ('C'), 10'h268 ('4'). keys=8'h81 gives
//    same output (lowest wins).
//  3 tx_ready held low 100 cycles in WAIT_RDY -> no frame_valid; release ->
//    one strobe only.
//  4 Toggle keys 0x01->0x02->0x04 during byte 1 -> current msg completes, then
//    exactly one msg "E4" (0x28A, 0x268).
//  5 Assert reset_n=0 during byte 2 -> outputs at reset values next cycle;
//    after release boot refresh resent.
//  6 SCREEN_MSG_CRLF_EN defined, keys=0x80 -> 0x218, 0x286, 0x26A, 0x21A,
//    0x214.
//  Check in all cases: never two frame_valid without an intervening
//    tx_ready==0; bytes never dropped or reordered.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared constants, note table, FSM state type and frame packing for the
// screen message builder. Optional build macro: SCREEN_MSG_CRLF_EN appends
// CR/LF to every message.
package screen_pkg;

    localparam int FRAME_BITS = 10;

    localparam logic [7:0] BYTE_CR   = 8'h0D;
    localparam logic [7:0] BYTE_LF   = 8'h0A;
    localparam logic [7:0] BYTE_DASH = 8'h2D;

`ifdef SCREEN_MSG_CRLF_EN
    localparam int MSG_LEN = 5;
`else
    localparam int MSG_LEN = 3;
`endif

    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

    // Note table, key index -> ASCII letter / octave digit: C4 D4 E4 F4 G4 A4 B4 C5
    localparam logic [7:0] NOTE_LETTER [8] = '{
        8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h41, 8'h42, 8'h43
    };
    localparam logic [7:0] NOTE_DIGIT [8] = '{
        8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h35
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        SEND,
        WAIT_ACK
    } state_t;

    // UART frame: stop bit high, data, start bit low (LSB goes out first)
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] dataByte);
        return {1'b1, dataByte, 1'b0};
    endfunction

endpackage

// File: rtl/key_change_detect.sv
// Two-flop synchronizer for the raw key levels, a snapshot of the last seen
// synchronized state, and a change flag that is high while they differ.
module key_change_detect #(
    parameter int NUM_KEYS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] snapshot,
    output logic                change
);

    logic [NUM_KEYS-1:0] keysMeta;
    logic [NUM_KEYS-1:0] keysSync;

    // Change is combinational so the snapshot update and pending set land together
    always_comb begin
        change = (keysSync != snapshot);
    end

    // Synchronizer chain and snapshot capture on change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keysMeta <= '0;
            keysSync <= '0;
            snapshot <= '0;
        end else begin
            keysMeta <= keys;
            keysSync <= keysMeta;
            if (change) begin
                snapshot <= keysSync;
            end
        end
    end

endmodule

// File: rtl/screen_msg_builder.sv
// Builds "clear, note letter, octave digit" messages whenever the key bitmap
// changes (plus once after reset) and hands them out as UART frames over a
// valid/ready handshake. Optional build macro: SCREEN_MSG_CRLF_EN.
module screen_msg_builder
    import screen_pkg::*;
#(
    parameter int         NUM_KEYS   = 8,
    parameter logic [7:0] CLEAR_BYTE = 8'h0C
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_KEYS-1:0]   keys,
    input  logic                  tx_ready,
    output logic                  frame_valid,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  busy
);

    logic [NUM_KEYS-1:0] snapshot;
    logic                keyChange;

    key_change_detect #(
        .NUM_KEYS(NUM_KEYS)
    ) u_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .keys    (keys),
        .snapshot(snapshot),
        .change  (keyChange)
    );

    state_t     state;
    logic       pending;
    logic [2:0] byteIdx;
    logic [7:0] letterQ;
    logic [7:0] digitQ;

    logic [2:0] noteIdx;
    logic       anyKey;
    logic [7:0] curByte;

    // Lowest pressed key wins: scan from the top so the last hit is the lowest
    always_comb begin
        noteIdx = '0;
        anyKey  = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snapshot[i]) begin
                anyKey  = 1'b1;
                noteIdx = 3'(i);
            end
        end
    end

    // Byte of the latched message selected by byteIdx; CR/LF slots are only
    // reachable when the message length includes them
    always_comb begin
        curByte = CLEAR_BYTE;
        case (byteIdx)
            3'd0:    curByte = CLEAR_BYTE;
            3'd1:    curByte = letterQ;
            3'd2:    curByte = digitQ;
            3'd3:    curByte = BYTE_CR;
            3'd4:    curByte = BYTE_LF;
            default: curByte = CLEAR_BYTE;
        endcase
    end

    // Message FSM with registered outputs; a key change sets pending after the
    // case so it wins over the clear in LOAD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= 1'b1;
            byteIdx     <= '0;
            letterQ     <= BYTE_DASH;
            digitQ      <= BYTE_DASH;
            frame_valid <= 1'b0;
            frame_data  <= '1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    letterQ <= anyKey ? NOTE_LETTER[noteIdx] : BYTE_DASH;
                    digitQ  <= anyKey ? NOTE_DIGIT[noteIdx] : BYTE_DASH;
                    pending <= 1'b0;
                    byteIdx <= '0;
                    busy    <= 1'b1;
                    state   <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    // Strobe only off a ready seen this cycle
                    if (tx_ready) begin
                        frame_valid <= 1'b1;
                        frame_data  <= make_frame(curByte);
                        state       <= SEND;
                    end
                end
                SEND: begin
                    frame_valid <= 1'b0;
                    state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Ready dropping means the transmitter took the frame
                    if (!tx_ready) begin
                        if (byteIdx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            byteIdx <= byteIdx + 3'd1;
                            state   <= WAIT_RDY;
                        end
                    end
                end
                default: begin
                    frame_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
            if (keyChange) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_screen_msg_builder.sv
// Directed bench for screen_msg_builder: boot refresh, note selection,
// ready stall, coalescing of changes, mid-message reset, optional CR/LF.
module tb_screen_msg_builder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_ready;
    logic [7:0] keys;
    logic       frame_valid;
    logic [9:0] frame_data;
    logic       busy;

    int errors      = 0;
    int checks      = 0;
    int strobeCount = 0;
    int expStrobes  = 0;
    int dupCount    = 0;
    bit armed       = 1'b1;

    always #5 clk = ~clk;

    screen_msg_builder #(
        .NUM_KEYS  (8),
        .CLEAR_BYTE(8'h0C)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keys       (keys),
        .tx_ready   (tx_ready),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .busy       (busy)
    );

    // Strobe counter; a strobe without tx_ready low since the previous one is a duplicate
    always @(negedge clk) begin
        if (!reset_n) begin
            armed = 1'b1;
        end else begin
            if (frame_valid) begin
                strobeCount++;
                if (!armed) dupCount++;
                armed = 1'b0;
            end
            if (!tx_ready) armed = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a strobe, check its frame, then act as the
    // transmitter: drop ready for one edge to acknowledge.
    task automatic expectFrame(input string tag, input logic [9:0] exp);
        int n = 0;
        while (frame_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        expStrobes++;
        check({tag, " strobe"}, 32'(frame_valid), 32'd1);
        check({tag, " data"}, 32'(frame_data), 32'(exp));
        tx_ready = 1'b0;
        @(negedge clk);
        check({tag, " width"}, 32'(frame_valid), 32'd0);
        @(negedge clk);
        tx_ready = 1'b1;
    endtask

    task automatic expectMsg(input string tag, input logic [9:0] ltr, input logic [9:0] dig);
        expectFrame({tag, " clr"}, 10'h218);
        expectFrame({tag, " ltr"}, ltr);
        expectFrame({tag, " dig"}, dig);
`ifdef SCREEN_MSG_CRLF_EN
        expectFrame({tag, " cr"}, 10'h21A);
        expectFrame({tag, " lf"}, 10'h214);
`endif
        check({tag, " busy end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        bit sawStrobe;

        reset_n  = 1'b0;
        keys     = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset valid", 32'(frame_valid), 32'd0);
        check("reset data", 32'(frame_data), 32'h3FF);
        check("reset busy", 32'(busy), 32'd0);

        // 1: boot refresh with no keys pressed
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t1 busy start", 32'(busy), 32'd1);
        expectMsg("t1", 10'h25A, 10'h25A);

        // 2: single key, latency, then lowest-index wins
        repeat (5) @(negedge clk);
        keys = 8'h01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_valid && n < 50);
        check("t2 latency>=5", 32'(n >= 5), 32'd1);
        expectMsg("t2 C4", 10'h286, 10'h268);
        keys = 8'h81;
        expectMsg("t2 C4 lowest", 10'h286, 10'h268);

        // 3: ready held low, no strobe, then exactly one per byte on release
        repeat (5) @(negedge clk);
        tx_ready  = 1'b0;
        keys      = 8'h02;
        sawStrobe = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (frame_valid) sawStrobe = 1'b1;
        end
        check("t3 stall nostrobe", 32'(sawStrobe), 32'd0);
        check("t3 stall busy", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        expectMsg("t3 D4", 10'h288, 10'h268);

        // 4: changes during byte 1 coalesce into one follow-up message
        repeat (5) @(negedge clk);
        keys = 8'h01;
        expectFrame("t4 clr", 10'h218);
        keys = 8'h02;
        @(negedge clk);
        keys = 8'h04;
        expectFrame("t4 ltr", 10'h286);
        expectFrame("t4 dig", 10'h268);
`ifdef SCREEN_MSG_CRLF_EN
        expectFrame("t4 cr", 10'h21A);
        expectFrame("t4 lf", 10'h214);
`endif
        expectMsg("t4 E4", 10'h28A, 10'h268);
        cnt = strobeCount;
        repeat (30) @(negedge clk);
        check("t4 no extra msg", 32'(strobeCount), 32'(cnt));

        // 5: reset just before byte 2, then boot refresh and the held key
        keys = 8'h10;
        expectFrame("t5 clr", 10'h218);
        expectFrame("t5 ltr", 10'h28E);
        reset_n = 1'b0;
        #1;
        check("t5 rst valid", 32'(frame_valid), 32'd0);
        check("t5 rst data", 32'(frame_data), 32'h3FF);
        check("t5 rst busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        expectMsg("t5 boot", 10'h25A, 10'h25A);
        expectMsg("t5 G4", 10'h28E, 10'h268);

        // 6: top key, C5 (plus CR/LF when enabled)
        repeat (5) @(negedge clk);
        keys = 8'h80;
        expectMsg("t6 C5", 10'h286, 10'h26A);

        repeat (20) @(negedge clk);
        check("total strobes", 32'(strobeCount), 32'(expStrobes));
        check("no duplicate strobe", 32'(dupCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
